// File: rtl/timer_acc.sv
// Programmable timer accumulator feeding the comparator section.
// Divides the sample-rate strobe TICK_IN by (PRE+1), counts the resulting
// steps into ACC, flags wrap in OVF and emits JKCK one cycle after each step.
module timer_acc #(
    parameter int WIDTH     = 8,
    parameter int PRE_WIDTH = 8
) (
    input  logic             CK,
    input  logic             nRES,
    input  logic [7:0]       PIN_DB_IN,
    input  logic             nWR_PRE,
    input  logic             nWR_CTRL,
    input  logic             TICK_IN,
    output logic [WIDTH-1:0] ACC,
    output logic             JKCK,
    output logic             OVF
);

    localparam logic [WIDTH-1:0]     ACC_ONE = 1;
    localparam logic [WIDTH-1:0]     ACC_MAX = '1;
    localparam logic [PRE_WIDTH-1:0] CNT_ONE = 1;

    // Bus value resized to the prescaler width
    logic [PRE_WIDTH-1:0] db_pre;

    generate
        if (PRE_WIDTH > 8) begin : g_pre_wide
            assign db_pre = {{(PRE_WIDTH-8){1'b0}}, PIN_DB_IN};
        end else if (PRE_WIDTH == 8) begin : g_pre_same
            assign db_pre = PIN_DB_IN;
        end else begin : g_pre_narrow
            assign db_pre = PIN_DB_IN[PRE_WIDTH-1:0];
        end
    endgenerate

    logic [PRE_WIDTH-1:0] pre_reg, pre_next;
    logic [PRE_WIDTH-1:0] cnt_reg, cnt_next;
    logic                 en_reg,  en_next;
    logic [WIDTH-1:0]     acc_reg, acc_next;
    logic                 ovf_reg, ovf_next;
    logic                 step_reg, step_next;
    logic                 jkck_reg;

    logic ctrl_wr;
    logic clr;
    logic ovf_clr;
    logic count;

    assign ctrl_wr = ~nWR_CTRL;
    assign clr     = ctrl_wr & PIN_DB_IN[1];
    assign ovf_clr = ctrl_wr & PIN_DB_IN[2];
    // A clear overrides counting; EN is the value held before this edge
    assign count   = en_reg & TICK_IN & ~clr;

    // Next-state computation for registers, prescaler and accumulator
    always_comb begin
        pre_next  = pre_reg;
        cnt_next  = cnt_reg;
        en_next   = en_reg;
        acc_next  = acc_reg;
        ovf_next  = ovf_reg;
        step_next = 1'b0;

        if (!nWR_PRE) begin
            pre_next = db_pre;
        end
        if (ctrl_wr) begin
            en_next = PIN_DB_IN[0];
        end

        if (clr) begin
            // Clear reloads from the freshly written PRE when both land together
            cnt_next = pre_next;
            acc_next = '0;
            ovf_next = 1'b0;
        end else if (count) begin
            if (cnt_reg != '0) begin
                cnt_next = cnt_reg - CNT_ONE;
            end else begin
                // Reload uses the PRE held before this edge
                cnt_next  = pre_reg;
                acc_next  = acc_reg + ACC_ONE;
                step_next = 1'b1;
                if (acc_reg == ACC_MAX) begin
                    ovf_next = 1'b1;
                end
            end
        end

        if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    // State register; JKCK trails the step by one cycle so ACC settles first
    always_ff @(posedge CK) begin
        if (!nRES) begin
            pre_reg  <= '0;
            cnt_reg  <= '0;
            en_reg   <= 1'b0;
            acc_reg  <= '0;
            ovf_reg  <= 1'b0;
            step_reg <= 1'b0;
            jkck_reg <= 1'b0;
        end else begin
            pre_reg  <= pre_next;
            cnt_reg  <= cnt_next;
            en_reg   <= en_next;
            acc_reg  <= acc_next;
            ovf_reg  <= ovf_next;
            step_reg <= step_next;
            jkck_reg <= step_reg;
        end
    end

    assign ACC  = acc_reg;
    assign JKCK = jkck_reg;
    assign OVF  = ovf_reg;

endmodule

// File: tb/tb_timer_acc.sv
// Directed testbench for timer_acc with hand-computed expectations.
module tb_timer_acc;

    logic       CK;
    logic       nRES;
    logic [7:0] PIN_DB_IN;
    logic       nWR_PRE;
    logic       nWR_CTRL;
    logic       TICK_IN;
    logic [7:0] ACC;
    logic       JKCK;
    logic       OVF;

    int check_cnt = 0;
    int err_cnt   = 0;

    timer_acc #(.WIDTH(8), .PRE_WIDTH(8)) dut (
        .CK        (CK),
        .nRES      (nRES),
        .PIN_DB_IN (PIN_DB_IN),
        .nWR_PRE   (nWR_PRE),
        .nWR_CTRL  (nWR_CTRL),
        .TICK_IN   (TICK_IN),
        .ACC       (ACC),
        .JKCK      (JKCK),
        .OVF       (OVF)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it
    task automatic clk_cycle();
        @(posedge CK);
        #1;
    endtask

    task automatic wr_pre(input logic [7:0] v);
        PIN_DB_IN = v;
        nWR_PRE   = 1'b0;
        clk_cycle();
        nWR_PRE   = 1'b1;
    endtask

    task automatic wr_ctrl(input logic [7:0] v);
        PIN_DB_IN = v;
        nWR_CTRL  = 1'b0;
        clk_cycle();
        nWR_CTRL  = 1'b1;
    endtask

    // n ticks, each followed by an idle cycle
    task automatic tick_spaced(input int n);
        for (int i = 0; i < n; i++) begin
            TICK_IN = 1'b1;
            clk_cycle();
            TICK_IN = 1'b0;
            clk_cycle();
        end
    endtask

    logic [7:0] exp_acc2  [8] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};
    logic       exp_jkck2 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        nRES      = 1'b0;
        PIN_DB_IN = 8'h01;
        nWR_PRE   = 1'b0;
        nWR_CTRL  = 1'b0;
        TICK_IN   = 1'b1;

        // 1: reset with ticks and writes active
        clk_cycle();
        clk_cycle();
        check("rst_acc", ACC, 0);
        check("rst_jkck", JKCK, 0);
        check("rst_ovf", OVF, 0);
        nRES     = 1'b1;
        nWR_PRE  = 1'b1;
        nWR_CTRL = 1'b1;
        clk_cycle();
        check("rst_tick_ignored_acc", ACC, 0);
        TICK_IN = 1'b0;
        clk_cycle();
        check("rst_tick_ignored_jkck", JKCK, 0);

        // 2: divide by 4
        wr_pre(8'd3);
        wr_ctrl(8'h03);
        for (int k = 0; k < 8; k++) begin
            TICK_IN = 1'b1;
            clk_cycle();
            check($sformatf("div_acc_t%0d", k + 1), ACC, exp_acc2[k]);
            check($sformatf("div_jkck_t%0d", k + 1), JKCK, exp_jkck2[k]);
        end
        TICK_IN = 1'b0;
        clk_cycle();
        check("div_jkck_after8", JKCK, 1);
        check("div_acc_final", ACC, 2);
        clk_cycle();
        check("div_jkck_width", JKCK, 0);

        // 3: wrap
        wr_pre(8'd0);
        wr_ctrl(8'h03);
        check("wrap_clr_acc", ACC, 0);
        tick_spaced(255);
        clk_cycle();
        check("wrap_pre_acc", ACC, 8'hFF);
        check("wrap_pre_ovf", OVF, 0);
        TICK_IN = 1'b1;
        clk_cycle();
        TICK_IN = 1'b0;
        check("wrap_acc", ACC, 0);
        check("wrap_ovf", OVF, 1);
        check("wrap_jkck_early", JKCK, 0);
        clk_cycle();
        check("wrap_jkck", JKCK, 1);
        clk_cycle();
        check("wrap_jkck_end", JKCK, 0);
        check("wrap_ovf_sticky", OVF, 1);
        wr_ctrl(8'h05);
        check("ovfclr_ovf", OVF, 0);
        check("ovfclr_acc", ACC, 0);

        // 4: clear beats a step in the same cycle
        tick_spaced(1);
        clk_cycle();
        check("cvs_pre_acc", ACC, 1);
        PIN_DB_IN = 8'h03;
        nWR_CTRL  = 1'b0;
        TICK_IN   = 1'b1;
        clk_cycle();
        nWR_CTRL  = 1'b1;
        TICK_IN   = 1'b0;
        check("cvs_acc", ACC, 0);
        clk_cycle();
        check("cvs_jkck1", JKCK, 0);
        clk_cycle();
        check("cvs_jkck2", JKCK, 0);

        // 5: freeze and resume
        wr_pre(8'd2);
        wr_ctrl(8'h03);
        tick_spaced(2);
        check("frz_acc_a", ACC, 0);
        wr_ctrl(8'h00);
        tick_spaced(5);
        check("frz_acc_b", ACC, 0);
        check("frz_jkck", JKCK, 0);
        wr_ctrl(8'h01);
        TICK_IN = 1'b1;
        clk_cycle();
        TICK_IN = 1'b0;
        check("frz_resume_acc", ACC, 1);
        clk_cycle();
        check("frz_resume_jkck", JKCK, 1);
        clk_cycle();

        // 6: reset with a step pending; JKCK must never appear
        wr_pre(8'd5);
        tick_spaced(2);
        TICK_IN = 1'b1;
        clk_cycle();
        TICK_IN = 1'b0;
        check("rmc_step_acc", ACC, 2);
        nRES = 1'b0;
        clk_cycle();
        nRES = 1'b1;
        check("rmc_acc", ACC, 0);
        check("rmc_jkck", JKCK, 0);
        check("rmc_ovf", OVF, 0);
        clk_cycle();
        check("rmc_jkck_late", JKCK, 0);
        TICK_IN = 1'b1;
        clk_cycle();
        TICK_IN = 1'b0;
        check("rmc_en_zero", ACC, 0);
        wr_ctrl(8'h01);
        TICK_IN = 1'b1;
        clk_cycle();
        TICK_IN = 1'b0;
        check("rmc_cnt_zero", ACC, 1);
        clk_cycle();
        check("rmc_jkck_after", JKCK, 1);
        TICK_IN = 1'b1;
        clk_cycle();
        TICK_IN = 1'b0;
        check("rmc_pre_zero", ACC, 2);
        clk_cycle();

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
